grid_write_scheduler: RTL and testbench
=======================================

// Module: grid_write_scheduler
// PURPOSE
//  Owns the 1-bit-per-cell display grid bitmap (GRID_ROWS x GRID_COLS, row-major) feeding the video path.
//  Shares write access between two requesters (req0, req1) with round-robin arbitration.
//  Sequences a full-screen clear on command.
//  Sole driver of grid_ram; the video scan logic only reads it.
// PARAMETERS
//  GRID_ROWS  30    grid height in cells
//  GRID_COLS  40    grid width in cells
//  CELLS      GRID_ROWS*GRID_COLS (1200)  bitmap length; localparam-style, not overridden
//  ADDR_W     11    cell address width; must satisfy 2**ADDR_W >= CELLS
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        async active-low reset
//  req0_valid   in   1        requester 0 write request
//  req0_addr    in   ADDR_W   linear cell index, row*GRID_COLS+col
//  req0_data    in   1        value to write (1=lit, 0=black)
//  req0_ready   out  1        grant to requester 0 (combinational)
//  req1_valid   in   1        requester 1 write request
//  req1_addr    in   ADDR_W   linear cell index
//  req1_data    in   1        value to write
//  req1_ready   out  1        grant to requester 1 (combinational)
//  clear_start  in   1        1-cycle pulse: start full-grid clear
//  clear_busy   out  1        high while clear sequence runs
//  clear_done   out  1        1-cycle pulse after the last cell is cleared
//  err_oob      out  1        1-cycle pulse: accepted write had addr >= CELLS
//  grid_ram     out  CELLS    registered bitmap; bit i = cell i
// BEHAVIOUR
//  Reset (async, reset_n low):
//   - grid_ram all 0; state IDLE; clear_ptr 0.
//   - clear_busy, clear_done, err_oob all 0.
//   - last_grant=1, so req0 wins the first contention.
//  State machine: IDLE, CLEAR.
//   - IDLE -> CLEAR on clear_start; clear_ptr <= 0.
//   - In CLEAR: each cycle grid_ram[clear_ptr] <= 0 and clear_ptr++.
//   - CLEAR -> IDLE on the cycle clear_ptr == CELLS-1 is written; clear_done pulses on the next cycle.
//   - A clear takes exactly CELLS cycles. clear_busy = (state==CLEAR), registered.
//   - clear_start while in CLEAR is ignored: no restart, no pointer reset.
//  Arbitration (IDLE only, and only when clear_start is low):
//   - One write accepted per cycle.
//   - Only one valid: that requester gets ready=1.
//   - Both valid: grant the requester != last_grant. last_grant updates only on an accepted transfer.
//   - Ready ignores the requester's own valid; it depends only on state, clear_start, the other valid and last_grant.
//   - In CLEAR, or when clear_start=1 in IDLE, both readies are 0. Clear wins same-cycle contention.
//  Transfer and write:
//   - Transfer occurs on valid && ready at a rising edge.
//   - grid_ram[addr] <= data is visible on the cycle after the transfer (latency 1).
//   - Writing a value equal to the current bit is legal: no change, no flag.
//  Out of range:
//   - addr >= CELLS is still accepted (ready follows the normal rules), but grid_ram is untouched.
//   - err_oob pulses high for 1 cycle, the cycle after the transfer.
//  Requester obligation: a requester holds valid/addr/data stable until ready. The block does not check this.
//  Reset mid-clear: state returns to IDLE and grid_ram is zeroed. No clear_done pulse.
// TESTING
//  T1 reset: hold reset_n=0 with random inputs -> grid_ram==0, both readies 0 only if clear_start=1, all flags 0.
//  T2 single writes: req0 addr=0 data=1, then req1 addr=1199 data=1
//     -> bits 0 and 1199 set one cycle after each handshake; no other bits change.
//  T3 contention: both valid for 4 cycles, addrs 5/6
//     -> grants alternate req0, req1, req0, req1; bits 5 and 6 set.
//  T4 clear: preload 100 bits, then pulse clear_start with both requesters valid
//     -> clear_busy high 1200 cycles, readies 0 throughout, grid_ram==0, clear_done pulses once,
//        then the pending req0 is granted first.
//  T5 out of range: req1 addr=1200 data=1 -> ready=1, err_oob pulses 1 cycle later, grid_ram unchanged.
//  T6 abort: reset_n low at clear cycle 600, then release
//     -> IDLE, grid_ram==0, no clear_done; a subsequent write works normally.

Source files
------------

// File: rtl/grid_write_scheduler.sv
// grid_write_scheduler
//   Owns the 1-bit-per-cell display bitmap (GRID_ROWS x GRID_COLS, row-major)
//   read by the video scan path. Two requesters share write access through a
//   round-robin arbiter, and a clear command walks the whole bitmap to zero,
//   one cell per cycle.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   req0_valid/addr/data      requester 0 write (addr = row*GRID_COLS+col)
//   req0_ready                combinational grant to requester 0
//   req1_valid/addr/data      requester 1 write
//   req1_ready                combinational grant to requester 1
//   clear_start               1-cycle pulse, starts a full-grid clear
//   clear_busy                high while the clear sequence runs
//   clear_done                1-cycle pulse after the last cell is cleared
//   err_oob                   1-cycle pulse after an accepted write with addr >= CELLS
//   grid_ram                  registered bitmap, bit i = cell i
module grid_write_scheduler #(
  parameter int GRID_ROWS = 30,
  parameter int GRID_COLS = 40,
  parameter int ADDR_W    = 11,
  localparam int CELLS    = GRID_ROWS * GRID_COLS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              err_oob,
  output logic [CELLS-1:0]  grid_ram
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  // One extra bit so the bound still compares correctly when 2**ADDR_W == CELLS.
  localparam logic [ADDR_W:0]   CELL_LIMIT = (ADDR_W + 1)'(CELLS);

  logic              state;
  logic [ADDR_W-1:0] clear_ptr;
  logic              last_grant;   // 0 = req0 won last transfer, 1 = req1

  logic              arb_open;
  logic              xfer0;
  logic              xfer1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_in_range;

  // A requester's ready never looks at its own valid: it is granted unless the
  // other side is also asking and it was the one served last.
  always_comb begin
    arb_open    = (state == ST_IDLE) && !clear_start;
    req0_ready  = arb_open && (!req1_valid || last_grant);
    req1_ready  = arb_open && (!req0_valid || !last_grant);
    xfer0       = req0_valid && req0_ready;
    xfer1       = req1_valid && req1_ready;
    wr_en       = xfer0 || xfer1;
    wr_addr     = xfer1 ? req1_addr : req0_addr;
    wr_data     = xfer1 ? req1_data : req0_data;
    wr_in_range = ({1'b0, wr_addr} < CELL_LIMIT);
  end

  assign clear_busy = (state == ST_CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      clear_ptr  <= '0;
      last_grant <= 1'b1;
      clear_done <= 1'b0;
      err_oob    <= 1'b0;
      grid_ram   <= '0;
    end else begin
      clear_done <= 1'b0;
      err_oob    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
          end else if (wr_en) begin
            last_grant <= xfer1;
            if (wr_in_range) begin
              grid_ram[wr_addr] <= wr_data;
            end else begin
              err_oob <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          grid_ram[clear_ptr] <= 1'b0;
          clear_ptr           <= clear_ptr + 1'b1;
          if (clear_ptr == LAST_CELL) begin
            state      <= ST_IDLE;
            clear_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_write_scheduler.sv
// Self-checking bench for grid_write_scheduler: a behavioural model of the
// bitmap, clear sequence and round-robin grant is compared against the DUT
// on every falling edge, alongside directed scenarios with literal results.
module tb_grid_write_scheduler;

  localparam int CELLS  = 1200;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic              req0_data = 1'b0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic              req1_data = 1'b0;
  logic              req1_ready;
  logic              clear_start = 1'b0;
  logic              clear_busy;
  logic              clear_done;
  logic              err_oob;
  logic [CELLS-1:0]  grid_ram;

  int n_checks = 0;
  int n_fail   = 0;

  grid_write_scheduler #(.GRID_ROWS(30), .GRID_COLS(40), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .err_oob(err_oob), .grid_ram(grid_ram)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_grid(input string name, input logic [CELLS-1:0] act, input logic [CELLS-1:0] exp);
    int first_diff;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      first_diff = -1;
      for (int i = CELLS - 1; i >= 0; i--) if (act[i] !== exp[i]) first_diff = i;
      $display("FAIL %s: got %0d lit cells expected %0d, first differing cell %0d at %0t",
               name, $countones(act), $countones(exp), first_diff, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [CELLS-1:0] m_ram = '0;
  bit m_busy = 1'b0;
  int m_cnt  = 0;    // cells cleared so far in the running clear
  int m_last = 1;    // requester that won the most recent transfer
  bit m_done = 1'b0;
  bit m_oob  = 1'b0;

  function automatic bit m_open();
    return !m_busy && !clear_start;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ram = '0; m_busy = 1'b0; m_cnt = 0; m_last = 1; m_done = 1'b0; m_oob = 1'b0;
    end else begin
      int g;
      int a;
      bit d;
      m_done = 1'b0;
      m_oob  = 1'b0;
      if (m_busy) begin
        m_ram[m_cnt] = 1'b0;
        m_cnt++;
        if (m_cnt == CELLS) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (clear_start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end else begin
        g = -1;
        if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
        if (g >= 0) begin
          a = (g == 0) ? int'(req0_addr) : int'(req1_addr);
          d = (g == 0) ? req0_data : req1_data;
          if (a < CELLS) m_ram[a] = d;
          else           m_oob = 1'b1;
          m_last = g;
        end
      end
    end
  end

  // Compare every cycle; a requester is ready when the arbiter is open and
  // either the other side is idle or this side is the one not served last.
  always @(negedge clk) begin
    chk("ready0", req0_ready, m_open() && (!req1_valid || m_last != 0));
    chk("ready1", req1_ready, m_open() && (!req0_valid || m_last != 1));
    chk("clear_busy", clear_busy, m_busy);
    chk("clear_done", clear_done, m_done);
    chk("err_oob", err_oob, m_oob);
    chk_grid("grid_ram", grid_ram, m_ram);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int grants[4];
    int busy_cnt;
    int done_cnt;
    int rdy_seen;

    // T1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      req0_valid  = 1'($urandom);
      req0_addr   = ADDR_W'($urandom_range(0, 2047));
      req0_data   = 1'($urandom);
      req1_valid  = 1'($urandom);
      req1_addr   = ADDR_W'($urandom_range(0, 2047));
      req1_data   = 1'($urandom);
      clear_start = 1'($urandom);
      step();
    end
    chk("rst_grid_pop", $countones(grid_ram), 0);
    chk("rst_flags", {clear_busy, clear_done, err_oob}, 0);
    req0_valid = 0; req1_valid = 0; clear_start = 0;
    req0_data = 0; req1_data = 0;
    reset_n = 1'b1;
    step();

    // T2: single writes
    req0_valid = 1; req0_addr = 0; req0_data = 1;
    step();
    req0_valid = 0;
    chk("t2_bit0", grid_ram[0], 1);
    chk("t2_pop1", $countones(grid_ram), 1);
    req1_valid = 1; req1_addr = 1199; req1_data = 1;
    step();
    req1_valid = 0;
    chk("t2_bit1199", grid_ram[1199], 1);
    chk("t2_pop2", $countones(grid_ram), 2);

    // T3: contention, req1 was served last so req0 goes first
    req0_valid = 1; req0_addr = 5; req0_data = 1;
    req1_valid = 1; req1_addr = 6; req1_data = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      grants[i] = req0_ready ? 0 : (req1_ready ? 1 : -1);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    chk("t3_grant0", grants[0], 0);
    chk("t3_grant1", grants[1], 1);
    chk("t3_grant2", grants[2], 0);
    chk("t3_grant3", grants[3], 1);
    chk("t3_bits56", {grid_ram[6], grid_ram[5]}, 2'b11);

    // T4: preload 100 bits through req1, then clear with both requesters pending
    for (int i = 0; i < 100; i++) begin
      req1_valid = 1; req1_addr = ADDR_W'(100 + i * 9); req1_data = 1;
      step();
    end
    req1_valid = 0;
    chk("t4_preload_pop", $countones(grid_ram), 104);
    clear_start = 1;
    req0_valid = 1; req0_addr = 20; req0_data = 1;
    req1_valid = 1; req1_addr = 30; req1_data = 1;
    @(negedge clk);
    chk("t4_ready_on_start", {req0_ready, req1_ready}, 0);
    step();
    clear_start = 0;
    busy_cnt = 0; done_cnt = 0; rdy_seen = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      if (clear_done) done_cnt++;
      if (!clear_busy) break;
      busy_cnt++;
      if (req0_ready || req1_ready) rdy_seen++;
      // a second start mid-clear must not restart the walk
      clear_start = (busy_cnt == 500);
    end
    clear_start = 0;
    chk("t4_busy_cycles", busy_cnt, 1200);
    chk("t4_ready_during_clear", rdy_seen, 0);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_grid_cleared", $countones(grid_ram), 0);
    chk("t4_first_grant", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 0;
    step();
    req1_valid = 0;
    chk("t4_bits_20_30", {grid_ram[30], grid_ram[20]}, 2'b11);
    chk("t4_pop", $countones(grid_ram), 2);

    // T5: out-of-range write
    req1_valid = 1; req1_addr = 11'd1200; req1_data = 1;
    @(negedge clk);
    chk("t5_ready", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("t5_oob_pulse", err_oob, 1);
    chk("t5_grid_unchanged", $countones(grid_ram), 2);
    step();
    chk("t5_oob_cleared", err_oob, 0);

    // T6: reset in the middle of a clear
    clear_start = 1;
    step();
    clear_start = 0;
    repeat (600) step();
    chk("t6_busy_mid", clear_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_busy_after_rst", clear_busy, 0);
    chk("t6_grid_after_rst", $countones(grid_ram), 0);
    step();
    step();
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (clear_done) done_cnt++;
    end
    chk("t6_no_done", done_cnt, 0);
    step();
    req0_valid = 1; req0_addr = 77; req0_data = 1;
    step();
    req0_valid = 0;
    chk("t6_write_bit77", grid_ram[77], 1);
    chk("t6_pop", $countones(grid_ram), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
